// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// One operation in flight: IDLE grants and registers operands, EXEC captures the result, RESP holds it.
module alu_arbiter #(
    parameter int DW  = 8,
    parameter int OPW = 4,
    parameter int FW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_opcode,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_opcode,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_out,
    input  logic [FW-1:0]  alu_flag,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data,
    output logic [FW-1:0]  rsp_flag,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           owner_q, owner_d;
    logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
    logic [DW-1:0]  alu_a_q, alu_a_d;
    logic [DW-1:0]  alu_b_q, alu_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic [FW-1:0]  rsp_flag_q, rsp_flag_d;
    logic           busy_q, busy_d;

    logic grant_any;
    logic grant_id;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == IDLE) & ~rst & grant_any & ~grant_id;
        req1_ready = (state_q == IDLE) & ~rst & grant_any & grant_id;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_flag_d   = rsp_flag_q;
        unique case (state_q)
            IDLE: begin
                if (req0_ready | req1_ready) begin
                    state_d      = EXEC;
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    alu_opcode_d = grant_id ? req1_opcode : req0_opcode;
                    alu_a_d      = grant_id ? req1_a : req0_a;
                    alu_b_d      = grant_id ? req1_b : req0_b;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_data_d  = alu_out;
                rsp_flag_d  = alu_flag;
                rsp_id_d    = owner_q;
                rsp_valid_d = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_flag_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_flag_q   <= rsp_flag_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_flag   = rsp_flag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two queue-fed requesters, a behavioural ALU, a transaction-level
// model checked every cycle, and directed literal expectations for the listed scenarios.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_opcode, req1_opcode, alu_opcode;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
    logic [3:0] alu_flag, rsp_flag;
    logic       rsp_valid, rsp_ready, rsp_id, busy;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(8), .OPW(4), .FW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .busy(busy)
    );

    // ALU: returns {flags(zero,neg,carry,0), result}
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            4'h0:    r = {1'b0, a} + {1'b0, b};
            4'h1:    r = {1'b0, a} - {1'b0, b};
            4'h2:    r = {1'b0, a & b};
            4'h3:    r = {1'b0, a ^ b};
            4'h4:    r = {1'b0, a | b};
            default: r = {1'b0, a};
        endcase
        return {(r[7:0] == 8'h00), r[7], r[8], 1'b0, r[7:0]};
    endfunction

    assign {alu_flag, alu_out} = alu_f(alu_opcode, alu_a, alu_b);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    logic [19:0] q0[$];
    logic [19:0] q1[$];

    // Requester agents: present queue head, hold it until accepted.
    initial begin
        bit f0, f1;
        req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
        forever begin
            @(negedge clk);
            f0 = req0_valid && req0_ready;
            f1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (f0 && q0.size() > 0) q0.delete(0);
            if (f1 && q1.size() > 0) q1.delete(0);
            if (q0.size() > 0) begin
                req0_valid = 1'b1;
                {req0_opcode, req0_a, req0_b} = q0[0];
            end else req0_valid = 1'b0;
            if (q1.size() > 0) begin
                req1_valid = 1'b1;
                {req1_opcode, req1_a, req1_b} = q1[0];
            end else req1_valid = 1'b0;
        end
    end

    // Transaction-level model and per-cycle comparison.
    bit          m_known = 1'b0;
    bit          m_inflight = 1'b0;
    int          m_age = 0;
    logic        m_id = 1'b0;
    logic        m_last = 1'b1;
    logic [19:0] m_op = '0;
    int          xfer_cyc[$];
    logic        grant_log[$];
    logic [7:0]  rsp_data_log[$];
    logic        rsp_id_log[$];
    int          rsp_cyc_log[$];

    initial begin
        bit exp_r0, exp_r1;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!m_known) begin
                if (rst) begin
                    m_known = 1'b1; m_inflight = 1'b0; m_last = 1'b1;
                end
            end else begin
                if (m_inflight) m_age++;
                exp_r0 = !rst && !m_inflight && req0_valid && (!req1_valid || m_last == 1'b1);
                exp_r1 = !rst && !m_inflight && req1_valid && (!req0_valid || m_last == 1'b0);
                chk("req0_ready", req0_ready, exp_r0);
                chk("req1_ready", req1_ready, exp_r1);
                chk("two_readies", req0_ready & req1_ready, 0);
                chk("busy", busy, m_inflight && m_age >= 0);
                chk("rsp_valid", rsp_valid, m_inflight && m_age >= 1);
                e = alu_f(m_op[19:16], m_op[15:8], m_op[7:0]);
                if (m_inflight && m_age >= 0) begin
                    chk("alu_opcode", alu_opcode, m_op[19:16]);
                    chk("alu_a", alu_a, m_op[15:8]);
                    chk("alu_b", alu_b, m_op[7:0]);
                end
                if (m_inflight && m_age >= 1) begin
                    chk("rsp_data", rsp_data, e[7:0]);
                    chk("rsp_flag", rsp_flag, e[11:8]);
                    chk("rsp_id", rsp_id, m_id);
                end
                if (rst) begin
                    m_inflight = 1'b0; m_last = 1'b1;
                end else if (exp_r0 || exp_r1) begin
                    m_inflight = 1'b1;
                    m_age      = -1;
                    m_id       = exp_r1;
                    m_last     = exp_r1;
                    m_op       = exp_r1 ? {req1_opcode, req1_a, req1_b} : {req0_opcode, req0_a, req0_b};
                    xfer_cyc.push_back(cyc);
                    grant_log.push_back(exp_r1);
                end else if (m_inflight && m_age >= 1 && rsp_ready) begin
                    rsp_data_log.push_back(rsp_data);
                    rsp_id_log.push_back(rsp_id);
                    rsp_cyc_log.push_back(cyc);
                    m_inflight = 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step(1);
            done = (q0.size() == 0) && (q1.size() == 0) && !m_inflight && !req0_valid && !req1_valid;
        end
        if (!done) chk("wait_done_timeout", 1, 0);
    endtask

    initial begin
        int base, xb, gb;
        logic [11:0] pin;
        logic exp_g[4];
        bit seen;
        rst = 1'b1;
        rsp_ready = 1'b1;
        step(3);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_alu_opcode", alu_opcode, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_flag", rsp_flag, 0);
        chk("reset_rsp_id", rsp_id, 0);
        pin = alu_f(4'h0, 8'h05, 8'h03); chk("pin_add", pin[7:0], 8'h08);
        pin = alu_f(4'h1, 8'h05, 8'h07); chk("pin_sub", pin[7:0], 8'hFE);
        pin = alu_f(4'h2, 8'hF0, 8'h0F); chk("pin_and", pin[7:0], 8'h00);
        pin = alu_f(4'h3, 8'h55, 8'hAA); chk("pin_xor", pin[7:0], 8'hFF);
        rst = 1'b0;

        // Single ADD from requester 0
        base = rsp_data_log.size(); xb = xfer_cyc.size();
        q0.push_back({4'h0, 8'h05, 8'h03});
        wait_done();
        chk("t1_count", rsp_data_log.size() - base, 1);
        if (rsp_data_log.size() > base && xfer_cyc.size() > xb) begin
            chk("t1_data", rsp_data_log[base], 8'h08);
            chk("t1_id", rsp_id_log[base], 0);
            chk("t1_latency", rsp_cyc_log[base] - xfer_cyc[xb], 2);
        end

        // Tie straight after reset: requester 0 first
        rst = 1'b1; step(1); rst = 1'b0;
        base = rsp_data_log.size();
        q0.push_back({4'h1, 8'h05, 8'h07});
        q1.push_back({4'h2, 8'hF0, 8'h0F});
        wait_done();
        chk("t2_count", rsp_data_log.size() - base, 2);
        if (rsp_data_log.size() >= base + 2) begin
            chk("t2_first_data", rsp_data_log[base], 8'hFE);
            chk("t2_first_id", rsp_id_log[base], 0);
            chk("t2_second_data", rsp_data_log[base+1], 8'h00);
            chk("t2_second_id", rsp_id_log[base+1], 1);
        end

        // Continuous contention alternates
        gb = grant_log.size();
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
        q0.push_back({4'h0, 8'h01, 8'h02}); q0.push_back({4'h0, 8'h03, 8'h04});
        q1.push_back({4'h2, 8'hFF, 8'h0F}); q1.push_back({4'h4, 8'h0F, 8'hF0});
        wait_done();
        chk("t3_count", grant_log.size() - gb, 4);
        if (grant_log.size() >= gb + 4)
            for (int i = 0; i < 4; i++) chk("t3_grant_order", grant_log[gb+i], exp_g[i]);

        // Consumer stalls in RESP while requester 1 waits
        rsp_ready = 1'b0;
        q0.push_back({4'h3, 8'h12, 8'h34});
        q1.push_back({4'h0, 8'h01, 8'h01});
        step(8);
        chk("t4_busy", busy, 1);
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_data", rsp_data, 8'h26);
        chk("t4_req1_ready", req1_ready, 0);
        rsp_ready = 1'b1;
        wait_done();

        // Reset during EXEC drops the op and restores the tie pointer
        base = rsp_data_log.size(); xb = xfer_cyc.size();
        q0.push_back({4'h0, 8'h10, 8'h20});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            seen = xfer_cyc.size() > xb;
        end
        chk("t5_transfer_seen", seen, 1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_busy", busy, 0);
        gb = grant_log.size();
        q0.push_back({4'h0, 8'h02, 8'h02});
        q1.push_back({4'h0, 8'h03, 8'h03});
        wait_done();
        chk("t5_count", rsp_data_log.size() - base, 2);
        if (grant_log.size() > gb) chk("t5_first_grant", grant_log[gb], 0);
        if (rsp_data_log.size() > base) chk("t5_first_data", rsp_data_log[base], 8'h04);

        // Back-to-back XOR from requester 1 only
        base = rsp_data_log.size(); xb = xfer_cyc.size();
        for (int i = 0; i < 3; i++) q1.push_back({4'h3, 8'h55, 8'hAA});
        wait_done();
        chk("t6_count", rsp_data_log.size() - base, 3);
        if (rsp_data_log.size() >= base + 3 && xfer_cyc.size() >= xb + 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t6_data", rsp_data_log[base+i], 8'hFF);
                chk("t6_id", rsp_id_log[base+i], 1);
            end
            chk("t6_spacing_a", xfer_cyc[xb+1] - xfer_cyc[xb], 3);
            chk("t6_spacing_b", xfer_cyc[xb+2] - xfer_cyc[xb+1], 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
